// File: rtl/lsu_dmem_bridge.sv
// rtl/lsu_dmem_bridge.sv - LSU to data-memory bus bridge with stall and timeout
// Registers a single-cycle LSU access into a valid/ready bus request, holding MW until completion.
module lsu_dmem_bridge #(
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic        wr,
  input  logic [3:0]  mask,
  input  logic [31:0] addr,
  input  logic [31:0] data_wr,
  output logic [31:0] data_rd,
  output logic        stall,
  output logic        mem_err,
  output logic        err_sticky,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_valid_q, bus_valid_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] data_rd_q, data_rd_d;
  logic        mem_err_q, mem_err_d;
  logic        err_sticky_q, err_sticky_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bus_valid_d  = bus_valid_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_be_d     = bus_be_q;
    data_rd_d    = data_rd_q;
    mem_err_d    = 1'b0;
    err_sticky_d = err_sticky_q;
    case (state_q)
      ST_IDLE: begin
        if (!cs) begin
          bus_valid_d = 1'b1;
          bus_we_d    = ~wr;
          bus_addr_d  = {addr[31:2], 2'b00};
          bus_wdata_d = data_wr;
          bus_be_d    = wr ? 4'hF : mask;
          cnt_d       = 8'd0;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        // bus_ready takes priority over a timeout expiring in the same cycle
        if (bus_ready) begin
          bus_valid_d = 1'b0;
          state_d     = ST_DONE;
          if (bus_err) begin
            mem_err_d    = 1'b1;
            err_sticky_d = 1'b1;
            if (!bus_we_q) data_rd_d = ERR_RDATA;
          end else if (!bus_we_q) begin
            data_rd_d = bus_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          bus_valid_d  = 1'b0;
          state_d      = ST_DONE;
          mem_err_d    = 1'b1;
          err_sticky_d = 1'b1;
          if (!bus_we_q) data_rd_d = ERR_RDATA;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      bus_valid_q  <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 32'd0;
      bus_wdata_q  <= 32'd0;
      bus_be_q     <= 4'b0000;
      data_rd_q    <= 32'd0;
      mem_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bus_valid_q  <= bus_valid_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_be_q     <= bus_be_d;
      data_rd_q    <= data_rd_d;
      mem_err_q    <= mem_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  // Low in DONE so the instruction leaves MW without re-issuing the access
  assign stall      = ((state_q == ST_IDLE) && !cs) || (state_q == ST_REQ);
  assign data_rd    = data_rd_q;
  assign mem_err    = mem_err_q;
  assign err_sticky = err_sticky_q;
  assign bus_valid  = bus_valid_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_be     = bus_be_q;

endmodule

// File: tb/tb_lsu_dmem_bridge.sv
// tb/tb_lsu_dmem_bridge.sv - self-checking bench for lsu_dmem_bridge
// Access vectors are applied by a cycle-level bus slave and compared against a rule-level model.
module tb_lsu_dmem_bridge;

  localparam int unsigned TO    = 4;
  localparam logic [31:0] ERR_W = 32'hDEAD_BEEF;

  logic        clk, rst_n, cs, wr;
  logic [3:0]  mask;
  logic [31:0] addr, data_wr, data_rd;
  logic        stall, mem_err, err_sticky;
  logic        bus_valid, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready, bus_err;
  logic [31:0] bus_rdata;

  lsu_dmem_bridge #(.TIMEOUT(TO), .ERR_RDATA(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .wr(wr), .mask(mask), .addr(addr),
    .data_wr(data_wr), .data_rd(data_rd), .stall(stall), .mem_err(mem_err),
    .err_sticky(err_sticky), .bus_valid(bus_valid), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
    logic        err;
    logic        keep;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_data_rd = 32'd0;
  logic        exp_sticky = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [3:0] m,
                              input logic [31:0] d, input int ws, input logic [31:0] r,
                              input logic e, input logic k);
    vec_t v;
    v.wr = w; v.addr = a; v.mask = m; v.wdata = d;
    v.waits = ws; v.rdata = r; v.err = e; v.keep = k;
    return v;
  endfunction

  // Entered at a falling edge with the bridge idle; leaves at a falling edge, idle again.
  task automatic access(input vec_t v);
    int k, valid_n, stall_n, exp_valid;
    logic exp_fail;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    e_addr  = {v.addr[31:2], 2'b00};
    e_wdata = v.wdata;
    e_be    = v.wr ? 4'hF : v.mask;
    cs = 1'b0; wr = v.wr; addr = v.addr; mask = v.mask; data_wr = v.wdata;
    bus_ready = 1'b0;
    #1;
    chk("idle_valid", 32'(bus_valid), 32'd0);
    stall_n = (stall === 1'b1) ? 1 : 0;
    @(posedge clk); @(negedge clk);
    k = 0; valid_n = 0;
    while (bus_valid === 1'b1 && k < 300) begin
      chk("req_addr", bus_addr, e_addr);
      chk("req_we", 32'(bus_we), 32'(!v.wr));
      chk("req_be", 32'(bus_be), 32'(e_be));
      chk("req_wdata", bus_wdata, e_wdata);
      chk("req_mem_err", 32'(mem_err), 32'd0);
      if (stall === 1'b1) stall_n++;
      valid_n++;
      wr = 1'($urandom); addr = $urandom; mask = 4'($urandom); data_wr = $urandom;
      if (k == v.waits) begin
        bus_ready = 1'b1; bus_rdata = v.rdata; bus_err = v.err;
      end else begin
        bus_ready = 1'b0; bus_rdata = $urandom; bus_err = 1'($urandom);
      end
      @(posedge clk); @(negedge clk);
      bus_ready = 1'b0;
      k++;
    end
    exp_valid = (v.waits < int'(TO)) ? v.waits + 1 : int'(TO);
    exp_fail  = (v.waits >= int'(TO)) || v.err;
    if (v.wr) exp_data_rd = exp_fail ? ERR_W : v.rdata;
    exp_sticky = exp_sticky | exp_fail;
    chk("valid_cycles", 32'(valid_n), 32'(exp_valid));
    chk("stall_cycles", 32'(stall_n), 32'(exp_valid + 1));
    chk("done_valid", 32'(bus_valid), 32'd0);
    chk("done_stall", 32'(stall), 32'd0);
    chk("done_mem_err", 32'(mem_err), 32'(exp_fail));
    chk("done_sticky", 32'(err_sticky), 32'(exp_sticky));
    chk("done_data_rd", data_rd, exp_data_rd);
    @(posedge clk); @(negedge clk);
    if (!v.keep) cs = 1'b1;
    #1;
    chk("after_valid", 32'(bus_valid), 32'd0);
    chk("after_mem_err", 32'(mem_err), 32'd0);
    chk("after_data_rd", data_rd, exp_data_rd);
    if (!v.keep) chk("after_stall", 32'(stall), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; cs = 1'b1; wr = 1'b0; mask = 4'h0; addr = 32'd0; data_wr = 32'd0;
    bus_ready = 1'b0; bus_rdata = 32'd0; bus_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(bus_valid), 32'd0);
    chk("rst_we", 32'(bus_we), 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    chk("rst_sticky", 32'(err_sticky), 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_be", 32'(bus_be), 32'd0);
    chk("rst_data_rd", data_rd, 32'd0);
    chk("rst_stall_cs1", 32'(stall), 32'd0);
    cs = 1'b0; #1;
    chk("rst_stall_cs0", 32'(stall), 32'd1);
    cs = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    vecs.push_back(mk(1'b1, 32'h0000_0106, 4'h0, 32'h0, 0, 32'hA1B2_C3D4, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0000_0203, 4'b1000, 32'h5A00_0000, 3, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0000_0300, 4'h0, 32'h0, 99, 32'h1111_1111, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0000_0400, 4'h0, 32'h0, 0, 32'h2222_2222, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 32'h0000_0404, 4'h0, 32'h0, 1, 32'h1234_5678, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0000_0500, 4'b0011, 32'h0000_BEEF, 0, 32'h0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 32'h0000_0508, 4'h0, 32'h0, 0, 32'h0BAD_F00D, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0000_0600, 4'b1111, 32'h7777_7777, 99, 32'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0000_0604, 4'b0100, 32'h0033_0000, 2, 32'h0, 1'b1, 1'b0));
    for (int i = 0; i < vecs.size(); i++) access(vecs[i]);

    for (int i = 0; i < 40; i++) begin
      access(mk(1'($urandom), $urandom, 4'($urandom_range(1, 15)), $urandom,
                $urandom_range(0, 5), $urandom, ($urandom_range(0, 3) == 0), 1'($urandom)));
    end
    cs = 1'b1;
    @(negedge clk);

    access(mk(1'b1, 32'h0000_0700, 4'h0, 32'h0, 0, 32'hCAFE_F00D, 1'b0, 1'b0));
    cs = 1'b0; wr = 1'b1; addr = 32'h0000_0800; bus_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0; #1;
    chk("midrst_valid", 32'(bus_valid), 32'd0);
    chk("midrst_data_rd", data_rd, 32'd0);
    chk("midrst_sticky", 32'(err_sticky), 32'd0);
    chk("midrst_stall", 32'(stall), 32'd1);
    cs = 1'b1;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1; #1;
    chk("postrst_stall", 32'(stall), 32'd0);
    chk("postrst_mem_err", 32'(mem_err), 32'd0);
    exp_data_rd = 32'd0;
    exp_sticky  = 1'b0;
    @(negedge clk);
    access(mk(1'b1, 32'h0000_0904, 4'h0, 32'h0, 1, 32'h5566_7788, 1'b0, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
